// File: rtl/shot_slot_scheduler_if.sv
// Bundle between the gun/collision side and the bullet drawers.
// The master drives fire, frame_tick, gun_x and hit; the scheduler owns the slot state outputs.
interface shot_slot_scheduler_if #(
    parameter int NUM_SLOTS = 8
);
    logic                      fire;
    logic                      frame_tick;
    logic [9:0]                gun_x;
    logic [NUM_SLOTS-1:0]      hit;
    logic [NUM_SLOTS-1:0]      slot_active;
    logic [10*NUM_SLOTS-1:0]   pos_x;
    logic [10*NUM_SLOTS-1:0]   pos_y;
    logic [3:0]                active_count;
    logic                      fire_accept;
    logic                      no_slot;

    modport master (
        output fire, frame_tick, gun_x, hit,
        input  slot_active, pos_x, pos_y, active_count, fire_accept, no_slot
    );

    modport slave (
        input  fire, frame_tick, gun_x, hit,
        output slot_active, pos_x, pos_y, active_count, fire_accept, no_slot
    );
endinterface

// File: rtl/shot_slot_scheduler.sv
// Bullet slot pool: allocates a slot at the gun for each fire press and moves/frees
// every live bullet once per frame, walking the slots one per clock during vertical blank.
module shot_slot_scheduler #(
    parameter int NUM_SLOTS = 8,
    parameter int GUN_Y     = 440,
    parameter int STEP      = 4,
    parameter int TOP_Y     = 0,
    parameter int COOLDOWN  = 8,
    parameter int OFF_Y     = 1023
) (
    input  logic                   vga_clk,
    input  logic                   reset,
    shot_slot_scheduler_if.slave   bus
);
    localparam logic [9:0] GUN_Y_V    = 10'(GUN_Y);
    localparam logic [9:0] STEP_V     = 10'(STEP);
    localparam logic [9:0] FREE_LIM   = 10'(TOP_Y + STEP);
    localparam logic [9:0] OFF_Y_V    = 10'(OFF_Y);
    localparam logic [7:0] COOLDOWN_V = 8'(COOLDOWN);
    localparam logic [2:0] LAST_IDX   = 3'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_UPDATE, ST_ALLOC} state_t;

    state_t               state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic                 sync1_q, sync2_q, sync3_q;
    logic                 pending_q, pending_d;
    logic [NUM_SLOTS-1:0] hit_latch_q, hit_latch_d;
    logic [NUM_SLOTS-1:0] active_q, active_d;
    logic [9:0]           x_q [NUM_SLOTS];
    logic [9:0]           x_d [NUM_SLOTS];
    logic [9:0]           y_q [NUM_SLOTS];
    logic [9:0]           y_d [NUM_SLOTS];
    logic [7:0]           cooldown_q, cooldown_d;
    logic [3:0]           count_q;
    logic                 fire_accept_q, fire_accept_d;
    logic                 no_slot_q, no_slot_d;
    logic                 fire_edge;
    logic                 free_found;
    logic [2:0]           free_idx;

    function automatic logic [3:0] popcount(input logic [NUM_SLOTS-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NUM_SLOTS; i++) n = n + 4'(v[i]);
        return n;
    endfunction

    assign fire_edge = sync2_q & ~sync3_q;

    // Lowest-index free slot; reflects any slot freed earlier in the same UPDATE pass.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                free_found = 1'b1;
                free_idx   = 3'(i);
            end
        end
    end

    // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        active_d      = active_q;
        x_d           = x_q;
        y_d           = y_q;
        cooldown_d    = cooldown_q;
        pending_d     = pending_q | fire_edge;
        hit_latch_d   = hit_latch_q | bus.hit;
        fire_accept_d = 1'b0;
        no_slot_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.frame_tick) begin
                    state_d = ST_UPDATE;
                    idx_d   = '0;
                end
            end
            ST_UPDATE: begin
                if (active_q[idx_q]) begin
                    if (hit_latch_q[idx_q] || bus.hit[idx_q] || (y_q[idx_q] < FREE_LIM)) begin
                        active_d[idx_q] = 1'b0;
                        x_d[idx_q]      = '0;
                        y_d[idx_q]      = OFF_Y_V;
                    end else begin
                        y_d[idx_q] = y_q[idx_q] - STEP_V;
                    end
                end
                hit_latch_d[idx_q] = 1'b0;
                if (idx_q == LAST_IDX) state_d = ST_ALLOC;
                else                   idx_d   = idx_q + 3'd1;
            end
            ST_ALLOC: begin
                state_d = ST_IDLE;
                if (cooldown_q != '0) begin
                    cooldown_d = cooldown_q - 8'd1;
                end else if (pending_q) begin
                    pending_d = fire_edge;
                    if (free_found) begin
                        active_d[free_idx] = 1'b1;
                        x_d[free_idx]      = bus.gun_x;
                        y_d[free_idx]      = GUN_Y_V;
                        cooldown_d         = COOLDOWN_V;
                        fire_accept_d      = 1'b1;
                    end else begin
                        no_slot_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            sync3_q       <= 1'b0;
            pending_q     <= 1'b0;
            hit_latch_q   <= '0;
            active_q      <= '0;
            cooldown_q    <= '0;
            count_q       <= '0;
            fire_accept_q <= 1'b0;
            no_slot_q     <= 1'b0;
            // NOTE: the slot arrays are small flop banks driving outputs, so they are reset like any register.
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= OFF_Y_V;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            sync1_q       <= bus.fire;
            sync2_q       <= sync1_q;
            sync3_q       <= sync2_q;
            pending_q     <= pending_d;
            hit_latch_q   <= hit_latch_d;
            active_q      <= active_d;
            x_q           <= x_d;
            y_q           <= y_d;
            cooldown_q    <= cooldown_d;
            count_q       <= popcount(active_q);
            fire_accept_q <= fire_accept_d;
            no_slot_q     <= no_slot_d;
        end
    end

    assign bus.slot_active  = active_q;
    assign bus.active_count = count_q;
    assign bus.fire_accept  = fire_accept_q;
    assign bus.no_slot      = no_slot_q;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
        assign bus.pos_x[10*g +: 10] = x_q[g];
        assign bus.pos_y[10*g +: 10] = y_q[g];
    end
endmodule

// File: tb/tb_shot_slot_scheduler.sv
// Self-checking bench for shot_slot_scheduler: a frame-level vector table plus hand-written
// sequences for same-cycle hits, mid-frame reset, bullet lifetime and repeated presses.
module tb_shot_slot_scheduler;
    localparam int N = 8;

    typedef enum logic [1:0] {EV_NONE, EV_ACC, EV_NOS} ev_t;

    typedef struct {
        logic         press;
        logic [9:0]   gx;
        logic [N-1:0] hit;
        ev_t          kind;
        int           slot;
        int           count;
        int           idle;
    } vec_t;

    typedef struct {
        ev_t        kind;
        int         slot;
        logic [9:0] x;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    vec_t vecs[16];

    shot_slot_scheduler_if #(.NUM_SLOTS(N)) bus ();

    shot_slot_scheduler #(.NUM_SLOTS(N)) dut (
        .vga_clk (clk),
        .reset   (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    function automatic logic [9:0] px(input int s);
        return bus.pos_x[10*s +: 10];
    endfunction

    function automatic logic [9:0] py(input int s);
        return bus.pos_y[10*s +: 10];
    endfunction

    task automatic push_exp(input ev_t k, input int s, input logic [9:0] x);
        exp_t e;
        e.kind = k;
        e.slot = s;
        e.x    = x;
        exp_q.push_back(e);
    endtask

    task automatic press_fire();
        bus.fire = 1'b1;
        repeat (4) @(posedge clk);
        #1 bus.fire = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_active"}, 128'(bus.slot_active), 128'(0));
        check({tag, "_count"},  128'(bus.active_count), 128'(0));
        check({tag, "_pos_x"},  128'(bus.pos_x), 128'(0));
        check({tag, "_pos_y"},  128'(bus.pos_y), 128'({N{10'd1023}}));
        check({tag, "_pulses"}, 128'({bus.fire_accept, bus.no_slot}), 128'(0));
    endtask

    // One frame: optional hit pulse (h_cyc<0: before the tick, else during UPDATE cycle h_cyc),
    // then the tick, then watch the outputs for the scheduler's event and compare against exp_q.
    task automatic frame(input logic [N-1:0] h, input int h_cyc);
        int   seen_c;
        exp_t e;
        ev_t  act;
        seen_c = -10;
        if (h_cyc < 0 && h != '0) begin
            bus.hit = h;
            @(posedge clk);
            #1 bus.hit = '0;
        end
        bus.frame_tick = 1'b1;
        @(posedge clk);
        #1 bus.frame_tick = 1'b0;
        for (int c = 1; c <= N + 4; c++) begin
            @(posedge clk);
            #1;
            if (c == seen_c + 1) begin
                check("pulse_width", 128'({bus.fire_accept, bus.no_slot}), 128'(0));
            end else if (bus.fire_accept || bus.no_slot) begin
                seen_c = c;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got accept=%0b no_slot=%0b want none",
                             bus.fire_accept, bus.no_slot);
                end else begin
                    e   = exp_q.pop_front();
                    act = bus.fire_accept ? EV_ACC : EV_NOS;
                    check("event_kind", 128'(act), 128'(e.kind));
                    check("event_latency", 128'(c), 128'(N + 1));
                    if (e.kind == EV_ACC) begin
                        check("alloc_active", 128'(bus.slot_active[e.slot]), 128'(1));
                        check("alloc_x", 128'(px(e.slot)), 128'(e.x));
                        check("alloc_y", 128'(py(e.slot)), 128'(440));
                    end
                end
            end
            bus.hit = (c == h_cyc) ? h : '0;
        end
        bus.hit = '0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_event: got none want %0d pending event(s)", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        // press, gun_x, hit, expected event, slot, active_count after, idle frames
        vecs[0]  = '{1'b1, 10'd300, 8'h00, EV_ACC,  0, 1, 3};
        vecs[1]  = '{1'b1, 10'd100, 8'h00, EV_NONE, 0, 1, 3};
        vecs[2]  = '{1'b0, 10'd100, 8'h00, EV_NONE, 0, 1, 0};
        vecs[3]  = '{1'b0, 10'd100, 8'h00, EV_ACC,  1, 2, 8};
        vecs[4]  = '{1'b1, 10'd20,  8'h00, EV_ACC,  2, 3, 8};
        vecs[5]  = '{1'b1, 10'd30,  8'h00, EV_ACC,  3, 4, 8};
        vecs[6]  = '{1'b1, 10'd40,  8'h00, EV_ACC,  4, 5, 8};
        vecs[7]  = '{1'b1, 10'd50,  8'h00, EV_ACC,  5, 6, 8};
        vecs[8]  = '{1'b1, 10'd60,  8'h00, EV_ACC,  6, 7, 8};
        vecs[9]  = '{1'b1, 10'd70,  8'h00, EV_ACC,  7, 8, 8};
        vecs[10] = '{1'b1, 10'd555, 8'h00, EV_NOS,  0, 8, 0};
        vecs[11] = '{1'b0, 10'd0,   8'h2A, EV_NONE, 0, 5, 0};
        vecs[12] = '{1'b1, 10'd777, 8'h00, EV_ACC,  1, 6, 8};
        vecs[13] = '{1'b1, 10'd123, 8'h20, EV_ACC,  3, 7, 8};
        vecs[14] = '{1'b1, 10'd321, 8'h00, EV_ACC,  5, 8, 0};
        vecs[15] = '{1'b0, 10'd0,   8'h00, EV_NONE, 0, 8, 0};

        bus.fire       = 1'b0;
        bus.frame_tick = 1'b0;
        bus.gun_x      = '0;
        bus.hit        = '0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            bus.gun_x = vecs[i].gx;
            if (vecs[i].press) press_fire();
            if (vecs[i].kind != EV_NONE) push_exp(vecs[i].kind, vecs[i].slot, vecs[i].gx);
            frame(vecs[i].hit, -1);
            check($sformatf("vec%0d_count", i), 128'(bus.active_count), 128'(vecs[i].count));
            repeat (vecs[i].idle) frame('0, -1);
        end
        check("full_slot0_x_kept", 128'(px(0)), 128'(300));
        check("full_slot7_x_kept", 128'(px(7)), 128'(70));

        // Hit arriving in the very cycle its slot is processed.
        frame(8'h04, 2);
        check("samecycle_hit_count", 128'(bus.active_count), 128'(7));
        frame('0, -1);
        check("samecycle_hit_active", 128'(bus.slot_active[2]), 128'(0));
        check("samecycle_hit_y", 128'(py(2)), 128'(1023));
        check("samecycle_hit_count2", 128'(bus.active_count), 128'(7));

        // Reset asserted while UPDATE is at idx=4.
        bus.frame_tick = 1'b1;
        @(posedge clk);
        #1 bus.frame_tick = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        #1 check_reset_outputs("midreset");
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus.gun_x = 10'd42;
        press_fire();
        push_exp(EV_ACC, 0, 10'd42);
        frame('0, -1);
        check("after_reset_count", 128'(bus.active_count), 128'(1));

        // Full lifetime of one bullet from the gun to the top of the screen.
        for (int k = 1; k <= 110; k++) begin
            frame('0, -1);
            check($sformatf("rise_y_%0d", k), 128'(py(0)), 128'(440 - 4 * k));
        end
        frame('0, -1);
        check("top_freed_y", 128'(py(0)), 128'(1023));
        check("top_freed_active", 128'(bus.slot_active[0]), 128'(0));
        check("top_freed_count", 128'(bus.active_count), 128'(0));

        // A press every frame for 40 frames: one shot per COOLDOWN+1 frames.
        for (int i = 0; i < 40; i++) begin
            bus.gun_x = 10'(500 + i);
            press_fire();
            if (i % 9 == 0) push_exp(EV_ACC, i / 9, 10'(500 + i));
            frame('0, -1);
        end
        check("repeat_count", 128'(bus.active_count), 128'(5));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
